regfile_multiport: RTL and testbench

Parametrised integer register file for the decode stage: XLEN-wide, NREGS-deep, NRD asynchronous read ports, one synchronous writeback port, hardwired-zero x0, a per-register pending-write scoreboard, and a sequential clear engine that zeroes the array after reset. It replaces the single-width, two-port file and feeds operand data plus hazard (busy) flags to the decode/issue logic.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/rf_scoreboard.sv | 48 ++++
 rtl/regfile_multiport.sv | 133 +++++++++++++
 tb/tb_regfile_multiport.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multiport register file.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.

package regfile_pkg;

    typedef enum logic {
        StClear = 1'b0,
        StReady = 1'b1
    } rf_state_e;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned NRD_DEF   = 2;

    function automatic int unsigned addr_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback.
// Bit 0 never sets so x0 always reads as not busy.

module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = NRD_DEF,
    parameter int unsigned AW    = addr_width(NREGS_DEF)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_set_en,
    input  logic [AW-1:0]     i_set_addr,
    input  logic              i_clr_en,
    input  logic [AW-1:0]     i_clr_addr,
    input  logic [NRD*AW-1:0] i_lookup_addr,
    output logic [NRD-1:0]    o_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // Set is applied after clear so a same-cycle issue to the written register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_en) begin
            w_busy_nxt[i_clr_addr] = 1'b0;
        end
        if (i_set_en) begin
            w_busy_nxt[i_set_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_lookup
        assign o_busy[k] = r_busy[i_lookup_addr[k*AW +: AW]];
    end

endmodule

// File: rtl/regfile_multiport.sv
// Multiport integer register file with hardwired x0, busy scoreboard and post-reset clear engine.
// Define REGFILE_BYPASS_EN to forward a same-cycle writeback to matching read ports.

module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = NRD_DEF,
    localparam int unsigned AW   = addr_width(NREGS)
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                init_done,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_addr
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BypassEn = 1'b1;
`else
    localparam bit BypassEn = 1'b0;
`endif

    rf_state_e       r_state;
    rf_state_e       w_state_nxt;
    logic [AW-1:0]   r_clr_cnt;
    logic [XLEN-1:0] r_regs [NREGS];

    logic            w_ready;
    logic            w_wr_en;
    logic [AW-1:0]   w_wr_addr;
    logic [XLEN-1:0] w_wr_data;
    logic            w_wb_valid;
    logic [NRD-1:0]  w_sb_busy;

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StClear;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StClear: begin
                if (r_clr_cnt == AW'(NREGS - 1)) begin
                    w_state_nxt = StReady;
                end
            end
            StReady: w_state_nxt = StReady;
        endcase
    end

    always_comb begin
        w_ready = (r_state == StReady);
    end

    assign init_done = w_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clr_cnt <= '0;
        end else if (r_state == StClear) begin
            r_clr_cnt <= r_clr_cnt + AW'(1);
        end
    end

    // ---------------- array write port ----------------
    assign w_wb_valid = w_ready && we && (wb_addr != '0);

    // The clear engine owns the single write port until the array is zeroed.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = r_clr_cnt;
        w_wr_data = '0;
        if (!w_ready) begin
            w_wr_en = 1'b1;
        end else if (w_wb_valid) begin
            w_wr_en   = 1'b1;
            w_wr_addr = wb_addr;
            w_wr_data = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_regs[w_wr_addr] <= w_wr_data;
        end
    end

    // ---------------- scoreboard ----------------
    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .i_clk         (clk),
        .i_rst_n       (reset_n),
        .i_set_en      (w_ready && iss_valid),
        .i_set_addr    (iss_addr),
        .i_clr_en      (w_wb_valid),
        .i_clr_addr    (wb_addr),
        .i_lookup_addr (rd_addr),
        .o_busy        (w_sb_busy)
    );

    // ---------------- read ports ----------------
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic            w_live;
        logic            w_fwd;
        logic [XLEN-1:0] w_data;

        assign w_addr = rd_addr[k*AW +: AW];
        assign w_live = w_ready && (w_addr != '0);
        assign w_fwd  = BypassEn && w_wb_valid && (wb_addr == w_addr);
        assign w_data = w_fwd ? wb_data : r_regs[w_addr];

        assign rd_data[k*XLEN +: XLEN] = w_live ? w_data : '0;
        assign rd_busy[k]              = w_live && !w_fwd && w_sb_busy[k];
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport: directed scenarios then randomized traffic
// checked against an array-based reference model.

module tb_regfile_multiport;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned AW    = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                init_done;
    logic [NRD*AW-1:0]   rd_addr = '0;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                we = 1'b0;
    logic [AW-1:0]       wb_addr = '0;
    logic [XLEN-1:0]     wb_data = '0;
    logic                iss_valid = 1'b0;
    logic [AW-1:0]       iss_addr = '0;

    always #5 clk = ~clk;

    regfile_multiport #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .init_done (init_done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .we        (we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural state only.
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];
    bit              m_ready = 1'b0;
    int              m_cnt = 0;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] port_data(input int k);
        return rd_data[k*XLEN +: XLEN];
    endfunction

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic idle();
        we = 1'b0;
        iss_valid = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [AW-1:0]   a;
        logic [XLEN-1:0] ed;
        logic            eb;
        chk({tag, ".init"}, XLEN'(init_done), XLEN'(m_ready));
        for (int k = 0; k < NRD; k++) begin
            a = rd_addr[k*AW +: AW];
            if (!m_ready || a == '0) begin
                ed = '0;
                eb = 1'b0;
            end else if (BYP && we && wb_addr == a) begin
                ed = wb_data;
                eb = 1'b0;
            end else begin
                ed = m_regs[a];
                eb = m_busy[a];
            end
            chk($sformatf("%s.data%0d", tag, k), port_data(k), ed);
            chk($sformatf("%s.busy%0d", tag, k), XLEN'(rd_busy[k]), XLEN'(eb));
        end
    endtask

    // Advance one clock edge and apply the architectural effect of the current inputs.
    task automatic tick();
        @(posedge clk);
        if (reset_n) begin
            if (m_ready) begin
                if (we && wb_addr != '0) begin
                    m_regs[wb_addr] = wb_data;
                    m_busy[wb_addr] = 1'b0;
                end
                if (iss_valid && iss_addr != '0) begin
                    m_busy[iss_addr] = 1'b1;
                end
            end else begin
                m_cnt++;
                if (m_cnt == NREGS) begin
                    m_ready = 1'b1;
                    for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
                end
            end
        end
        #1;
    endtask

    task automatic model_reset();
        m_ready = 1'b0;
        m_cnt = 0;
        for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
    endtask

    // Assert reset mid-cycle, check reset outputs, release just after the next edge.
    task automatic pulse_reset(input string tag);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < 100) begin
            #2;
            check_all({tag, ".clr"});
            tick();
            n++;
        end
        chk({tag, ".latency"}, XLEN'(n), XLEN'(NREGS));
    endtask

    initial begin
        model_reset();
        for (int r = 0; r < NREGS; r++) m_regs[r] = '0;

        // Reset state
        set_rd(5'd7, 5'd31);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset_n = 1'b1;

        // Clear with writes/issues to x4 that must be ignored
        iss_valid = 1'b1;
        iss_addr  = 5'd4;
        we        = 1'b1;
        wb_addr   = 5'd4;
        wb_data   = 32'h0000_00FF;
        set_rd(5'd4, 5'd4);
        wait_ready("init");
        idle();
        #2;
        check_all("x4");
        chk("x4_zero", port_data(0), 32'h0);
        chk("x4_notbusy", XLEN'(rd_busy[0]), 32'h0);
        tick();

        // Write x5, then attempt write to x0
        we = 1'b1;
        wb_addr = 5'd5;
        wb_data = 32'hDEAD_BEEF;
        set_rd(5'd5, 5'd0);
        #2;
        check_all("wr5");
        tick();
        wb_addr = 5'd0;
        wb_data = 32'h1234_5678;
        #2;
        check_all("wr0");
        tick();
        idle();
        #2;
        chk("x5_read", port_data(0), 32'hDEAD_BEEF);
        chk("x0_read", port_data(1), 32'h0);

        // Same-cycle write and read of x7
        we = 1'b1;
        wb_addr = 5'd7;
        wb_data = 32'h1111_1111;
        tick();
        wb_data = 32'hA5A5_A5A5;
        set_rd(5'd7, 5'd7);
        #2;
        check_all("x7_same");
        chk("x7_same_cycle", port_data(0), BYP ? 32'hA5A5_A5A5 : 32'h1111_1111);
        tick();
        idle();
        #2;
        chk("x7_next_cycle", port_data(0), 32'hA5A5_A5A5);

        // Scoreboard: issue, writeback+reissue, final writeback
        iss_valid = 1'b1;
        iss_addr = 5'd3;
        set_rd(5'd3, 5'd3);
        tick();
        idle();
        tick();
        tick();
        #2;
        chk("x3_busy", XLEN'(rd_busy[0]), 32'h1);
        we = 1'b1;
        wb_addr = 5'd3;
        wb_data = 32'h33;
        iss_valid = 1'b1;
        iss_addr = 5'd3;
        check_all("x3_wb_iss");
        tick();
        idle();
        #2;
        chk("x3_still_busy", XLEN'(rd_busy[1]), 32'h1);
        we = 1'b1;
        wb_data = 32'h34;
        tick();
        idle();
        #2;
        chk("x3_cleared", XLEN'(rd_busy[0]), 32'h0);
        chk("x3_value", port_data(1), 32'h34);

        // Issue to x0 never marks busy
        iss_valid = 1'b1;
        iss_addr = 5'd0;
        set_rd(5'd0, 5'd3);
        tick();
        idle();
        #2;
        check_all("x0_iss");
        chk("x0_notbusy", XLEN'(rd_busy[0]), 32'h0);

        // Reset at clear cycle 10
        pulse_reset("rst_a");
        for (int i = 0; i < 10; i++) begin
            #2;
            check_all("clr10");
            tick();
        end
        pulse_reset("rst_mid");
        wait_ready("reinit");

        // Reset in READY with x9 busy and holding 1
        we = 1'b1;
        wb_addr = 5'd9;
        wb_data = 32'h1;
        tick();
        we = 1'b0;
        iss_valid = 1'b1;
        iss_addr = 5'd9;
        tick();
        idle();
        set_rd(5'd9, 5'd9);
        #2;
        chk("x9_pre_busy", XLEN'(rd_busy[0]), 32'h1);
        chk("x9_pre_data", port_data(1), 32'h1);
        pulse_reset("rst_ready");
        wait_ready("reinit2");
        #2;
        chk("x9_post_data", port_data(0), 32'h0);
        chk("x9_post_busy", XLEN'(rd_busy[1]), 32'h0);
        tick();

        // Randomized traffic on a narrow address range to provoke collisions
        for (int i = 0; i < 400; i++) begin
            we        = 1'($urandom_range(0, 1));
            wb_addr   = AW'($urandom_range(0, 7));
            wb_data   = $urandom;
            iss_valid = 1'($urandom_range(0, 1));
            iss_addr  = AW'($urandom_range(0, 7));
            set_rd(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            #2;
            check_all("rand");
            tick();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
